param_averager: RTL and testbench
=================================

PARAM_AVERAGER -- requirements
Module: param_averager

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the sample and result width in bits (legal range 2..16).
REQ-002 The block SHALL have parameter LOG2_N, default 2, meaning samples per average = 2^LOG2_N (legal range 0..8).
REQ-003 The block SHALL have port clk_2, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port find_average, input, 1 bit: the enable; while high, the block collects and averages sample blocks.
REQ-006 The block SHALL have port sample_valid, input, 1 bit: sample_data is valid this cycle.
REQ-007 The block SHALL have port sample_data, input, DATA_W bits: unsigned sample.
REQ-008 The block SHALL have port sample_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-009 The block SHALL have port average_ack, input, 1 bit: the consumer has taken average_result.
REQ-010 The block SHALL have port average_result, output, DATA_W bits: registered unsigned average.
REQ-011 The block SHALL have port average_done, output, 1 bit: average_result is valid, held until acknowledged.
REQ-012 The block SHALL have port sample_count, output, LOG2_N+1 bits: number of samples accepted in the current block.

Function
REQ-013 The block SHALL implement the states IDLE, ACCUM and DONE.
REQ-014 A sample SHALL be accepted only on a cycle where both sample_valid and sample_ready are 1.
REQ-015 sample_ready SHALL be 1 only in ACCUM, and 0 in IDLE and DONE.
REQ-016 IDLE with find_average=1 SHALL go to ACCUM, clearing the accumulator and sample_count.
REQ-017 In ACCUM, each accepted sample SHALL be added to the accumulator and sample_count SHALL increment by one.
REQ-018 The accumulator SHALL be DATA_W+LOG2_N+1 bits wide, and SHALL never overflow.
REQ-019 On the 2^LOG2_N-th accepted sample, at the next edge the block SHALL: enter DONE, load average_result from the final sum including that sample, and assert average_done.
REQ-020 The latency from the last accepted sample to average_done=1 SHALL be exactly 1 cycle.
REQ-021 Without gaps in sample_valid, a block SHALL take 2^LOG2_N cycles in ACCUM.
REQ-022 ACCUM with find_average=0 SHALL return to IDLE at the next edge, discarding the partial sum; sample_count SHALL clear and average_done SHALL stay 0.
REQ-023 In DONE, average_result and average_done SHALL hold until the cycle average_ack=1.
REQ-024 DONE with average_ack=1 SHALL go to ACCUM (cleared) if find_average=1, else to IDLE; average_done SHALL fall at the same edge.
REQ-025 average_ack SHALL be ignored outside DONE.
REQ-026 find_average=0 while in DONE SHALL not drop the pending result; the block SHALL leave DONE only on average_ack.
REQ-027 With LOG2_N=0, every accepted sample SHALL pass unchanged to average_result with 1-cycle latency.
REQ-028 sample_count SHALL equal 2^LOG2_N while in DONE, and 0 in IDLE.

Reset
REQ-029 reset_n=0 SHALL immediately force state to IDLE, clear the accumulator, and set sample_count=0, average_result=0, average_done=0 and sample_ready=0.
REQ-030 Reset asserted mid-ACCUM or in DONE SHALL discard all partial and pending results.
REQ-031 After reset_n rises, the block SHALL behave per REQ-016 from the first clock edge.

Configuration
REQ-032 Macro AVG_ROUND_EN SHALL select the rounding mode.
REQ-033 With AVG_ROUND_EN defined, average_result SHALL be (sum + 2^(LOG2_N-1)) >> LOG2_N for LOG2_N>0 (round half up), and SHALL never exceed 2^DATA_W-1.
REQ-034 Without AVG_ROUND_EN, average_result SHALL be sum >> LOG2_N (truncation).

Verification (DATA_W=8, LOG2_N=2)
REQ-035 Samples 10,20,30,42 back-to-back -> average_done=1 one cycle after the 4th sample; average_result=25, or 26 with AVG_ROUND_EN.
REQ-036 Four samples of 255, with valid gaps of 0–3 cycles between them -> average_result=255 in both modes, and sample_count steps 1,2,3,4.
REQ-037 find_average dropped after 2 accepted samples -> IDLE next cycle, average_done never asserts; a new block of 4×8 -> result 8.
REQ-038 Hold average_ack=0 for 10 cycles in DONE while sample_valid=1 -> result stable, sample_ready=0; ack with find_average=1 -> ACCUM and the next block averages correctly.
REQ-039 reset_n pulsed low mid-ACCUM after 3 samples and again while in DONE -> all outputs 0 asynchronously; the next full block is unaffected by the prior sum.
REQ-040 LOG2_N=0 build, samples 7,200 back-to-back with ack each cycle -> results 7 then 200, each 1 cycle after acceptance.

Source files
------------

// File: rtl/param_averager_if.sv
// rtl/param_averager_if.sv - sample/result handshake bundle for param_averager
interface param_averager_if #(
   parameter int DATA_W = 8,
   parameter int LOG2_N = 2
);
   logic              find_average;
   logic              sample_valid;
   logic [DATA_W-1:0] sample_data;
   logic              sample_ready;
   logic              average_ack;
   logic [DATA_W-1:0] average_result;
   logic              average_done;
   logic [LOG2_N:0]   sample_count;

   modport master (
      output find_average, sample_valid, sample_data, average_ack,
      input  sample_ready, average_result, average_done, sample_count
   );

   modport slave (
      input  find_average, sample_valid, sample_data, average_ack,
      output sample_ready, average_result, average_done, sample_count
   );
endinterface

// File: rtl/param_averager.sv
// rtl/param_averager.sv - block averager over 2^LOG2_N samples; AVG_ROUND_EN selects round-half-up
module param_averager #(
   parameter int DATA_W = 8,
   parameter int LOG2_N = 2
) (
   input logic             clk_2,
   input logic             reset_n,
   param_averager_if.slave avg
);
   localparam int ACC_W = DATA_W + LOG2_N + 1;
   localparam int CNT_W = LOG2_N + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(1 << LOG2_N);
`ifdef AVG_ROUND_EN
   localparam logic [ACC_W-1:0] HALF = ACC_W'((1 << LOG2_N) >> 1);
`else
   localparam logic [ACC_W-1:0] HALF = '0;
`endif

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t            state_q, state_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] result_q, result_d;

   logic [ACC_W-1:0]  sum;
   logic [ACC_W-1:0]  rounded;
   logic [ACC_W-1:0]  shifted;
   logic [CNT_W-1:0]  cnt_inc;
   logic              unused_shift_bits;

   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   // The spare accumulator bit keeps sum + HALF from wrapping, so the shifted
   // result always fits in DATA_W bits.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      sum      = acc_q + ACC_W'(avg.sample_data);
      rounded  = sum + HALF;
      shifted  = rounded >> LOG2_N;
      cnt_inc  = cnt_q + 1'b1;

      case (state_q)
         IDLE: begin
            if (avg.find_average) begin
               state_d = ACCUM;
               acc_d   = '0;
               cnt_d   = '0;
            end
         end
         ACCUM: begin
            if (!avg.find_average) begin
               state_d = IDLE;
               acc_d   = '0;
               cnt_d   = '0;
            end else if (avg.sample_valid) begin
               acc_d = sum;
               cnt_d = cnt_inc;
               if (cnt_inc == FULL) begin
                  state_d  = DONE;
                  result_d = shifted[DATA_W-1:0];
               end
            end
         end
         DONE: begin
            // Pending result survives find_average=0; only the ack releases it.
            if (avg.average_ack) begin
               state_d = avg.find_average ? ACCUM : IDLE;
               acc_d   = '0;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
         end
      endcase
   end

   assign unused_shift_bits  = ^shifted[ACC_W-1:DATA_W];

   assign avg.sample_ready   = (state_q == ACCUM) && avg.find_average;
   assign avg.average_done   = (state_q == DONE);
   assign avg.average_result = result_q;
   assign avg.sample_count   = cnt_q;
endmodule

// File: tb/tb_param_averager.sv
// tb/tb_param_averager.sv - scoreboard bench for param_averager (LOG2_N=2 and LOG2_N=0 instances)
module tb_param_averager;
   logic clk_2;
   logic reset_n;

   param_averager_if #(.DATA_W(8), .LOG2_N(2)) bus ();
   param_averager_if #(.DATA_W(8), .LOG2_N(0)) bus0 ();

   param_averager #(.DATA_W(8), .LOG2_N(2)) dut (
      .clk_2   (clk_2),
      .reset_n (reset_n),
      .avg     (bus.slave)
   );

   param_averager #(.DATA_W(8), .LOG2_N(0)) dut0 (
      .clk_2   (clk_2),
      .reset_n (reset_n),
      .avg     (bus0.slave)
   );

   initial clk_2 = 1'b0;
   always #5 clk_2 = ~clk_2;

   int n_checks = 0;
   int n_errors = 0;
   int exp_q[$];
   int exp0_q[$];
   int cyc = 0;
   int last_acc = -10;
   int last_acc0 = -10;
   logic prev_done = 1'b0;
   logic prev_done0 = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic int avg4(input int s);
`ifdef AVG_ROUND_EN
      return (s + 2) >> 2;
`else
      return s >> 2;
`endif
   endfunction

   // Scoreboard: results are compared on the rising edge of average_done,
   // which must follow the last accepted sample by exactly one cycle.
   always @(negedge clk_2) begin
      cyc++;
      if (bus.average_done && !prev_done) begin
         if (exp_q.size() == 0) begin
            check_eq("spurious_done", 1, 0);
         end else begin
            check_eq("result", bus.average_result, exp_q.pop_front());
            check_eq("latency", cyc - last_acc, 1);
         end
      end
      prev_done = bus.average_done;
      if (bus.sample_valid && bus.sample_ready) last_acc = cyc;

      if (bus0.average_done && !prev_done0) begin
         if (exp0_q.size() == 0) begin
            check_eq("n0_spurious_done", 1, 0);
         end else begin
            check_eq("n0_result", bus0.average_result, exp0_q.pop_front());
            check_eq("n0_latency", cyc - last_acc0, 1);
         end
      end
      prev_done0 = bus0.average_done;
      if (bus0.sample_valid && bus0.sample_ready) last_acc0 = cyc;
   end

   // Called at the negedge phase; returns at the negedge after acceptance.
   task automatic send_sample(input logic [7:0] d, input int gap, input int exp_cnt);
      bit ok;
      bus.sample_valid = 1'b0;
      repeat (gap) @(negedge clk_2);
      bus.sample_valid = 1'b1;
      bus.sample_data  = d;
      ok = 1'b0;
      for (int t = 0; t < 20; t++) begin
         if (bus.sample_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk_2);
      end
      if (!ok) check_eq("ready_timeout", 0, 1);
      @(posedge clk_2);
      #1;
      bus.sample_valid = 1'b0;
      @(negedge clk_2);
      check_eq("sample_count", bus.sample_count, exp_cnt);
   endtask

   task automatic send_block(input int s0, input int s1, input int s2, input int s3,
                             input int gap, input int exp);
      exp_q.push_back(exp);
      send_sample(8'(s0), 0, 1);
      send_sample(8'(s1), gap >= 0 ? gap : 1, 2);
      send_sample(8'(s2), gap >= 0 ? gap : 2, 3);
      send_sample(8'(s3), gap >= 0 ? gap : 3, 4);
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 50; t++) begin
         if (exp_q.size() == 0 && exp0_q.size() == 0) return;
         @(negedge clk_2);
      end
      check_eq("drain_timeout", exp_q.size() + exp0_q.size(), 0);
   endtask

   task automatic check_zero_outputs(input string tag);
      check_eq({tag, "_ready"}, bus.sample_ready, 0);
      check_eq({tag, "_done"}, bus.average_done, 0);
      check_eq({tag, "_count"}, bus.sample_count, 0);
      check_eq({tag, "_result"}, bus.average_result, 0);
   endtask

   initial begin
      int held;
      reset_n           = 1'b0;
      bus.find_average  = 1'b0;
      bus.sample_valid  = 1'b0;
      bus.sample_data   = '0;
      bus.average_ack   = 1'b1;
      bus0.find_average = 1'b0;
      bus0.sample_valid = 1'b0;
      bus0.sample_data  = '0;
      bus0.average_ack  = 1'b1;
      #12;
      check_zero_outputs("reset");
      @(negedge clk_2);
      reset_n = 1'b1;
      bus.find_average = 1'b1;
      @(negedge clk_2);

`ifdef AVG_ROUND_EN
      send_block(10, 20, 30, 42, 0, 26);
`else
      send_block(10, 20, 30, 42, 0, 25);
`endif
      wait_drain();

      send_block(255, 255, 255, 255, -1, 255);
      wait_drain();

      send_sample(8'd50, 0, 1);
      send_sample(8'd60, 0, 2);
      bus.find_average = 1'b0;
      @(posedge clk_2);
      @(negedge clk_2);
      check_eq("abort_count", bus.sample_count, 0);
      check_eq("abort_ready", bus.sample_ready, 0);
      check_eq("abort_done", bus.average_done, 0);
      bus.find_average = 1'b1;
      @(negedge clk_2);
      send_block(8, 8, 8, 8, 0, 8);
      wait_drain();

      bus.average_ack = 1'b0;
      send_block(1, 2, 3, 4, 0, avg4(10));
      wait_drain();
      bus.sample_valid = 1'b1;
      bus.sample_data  = 8'd99;
      bus.find_average = 1'b0;
      for (held = 0; held < 10; held++) begin
         @(negedge clk_2);
         check_eq("hold_result", bus.average_result, avg4(10));
         check_eq("hold_done", bus.average_done, 1);
         check_eq("hold_ready", bus.sample_ready, 0);
         check_eq("hold_count", bus.sample_count, 4);
      end
      bus.sample_valid = 1'b0;
      bus.find_average = 1'b1;
      bus.average_ack  = 1'b1;
      @(posedge clk_2);
      #1;
      bus.average_ack = 1'b0;
      check_eq("ack_done_fall", bus.average_done, 0);
      check_eq("ack_to_accum", bus.sample_ready, 1);
      bus.average_ack = 1'b1;
      @(negedge clk_2);
      send_block(100, 101, 102, 103, 0, avg4(406));
      wait_drain();

      send_sample(8'd200, 0, 1);
      send_sample(8'd200, 0, 2);
      send_sample(8'd200, 0, 3);
      @(posedge clk_2);
      #1;
      reset_n = 1'b0;
      #1;
      check_zero_outputs("rst_accum");
      @(negedge clk_2);
      reset_n = 1'b1;
      @(negedge clk_2);
      send_block(4, 4, 4, 4, 0, 4);
      wait_drain();

      bus.average_ack = 1'b0;
      send_block(60, 60, 60, 60, 0, 60);
      wait_drain();
      @(posedge clk_2);
      #1;
      reset_n = 1'b0;
      #1;
      check_zero_outputs("rst_done");
      @(negedge clk_2);
      reset_n = 1'b1;
      bus.average_ack = 1'b1;
      @(negedge clk_2);
      send_block(12, 13, 14, 15, 0, avg4(54));
      wait_drain();

      exp0_q.push_back(7);
      exp0_q.push_back(200);
      bus0.find_average = 1'b1;
      bus0.sample_valid = 1'b1;
      bus0.sample_data  = 8'd7;
      for (int k = 0; k < 2; k++) begin
         bit ok;
         ok = 1'b0;
         for (int t = 0; t < 20; t++) begin
            @(negedge clk_2);
            if (bus0.sample_ready) begin
               ok = 1'b1;
               break;
            end
         end
         if (!ok) check_eq("n0_ready_timeout", 0, 1);
         @(posedge clk_2);
         #1;
         bus0.sample_data = 8'd200;
      end
      bus0.sample_valid = 1'b0;
      @(negedge clk_2);
      wait_drain();
      repeat (3) @(negedge clk_2);
      check_eq("queue_empty", exp_q.size() + exp0_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
